// File: rtl/mem_stage_lsu_if.sv
// Execute-to-writeback bus for the MEM stage: M-side request fields in, MEM/WB register fields out.
// The master is the pipeline around the stage; the slave is mem_stage_lsu itself.
interface mem_stage_lsu_if;
    logic        regwriteM;
    logic        memrwM;
    logic        memreadM;
    logic [2:0]  funct3M;
    logic [1:0]  wbselM;
    logic [4:0]  rdM;
    logic [31:0] data_writeM;
    logic [31:0] ALUresM;
    logic [31:0] pc4M;
    logic        stallM;
    logic        flushW;

    logic        regwriteW;
    logic [1:0]  wbselW;
    logic [4:0]  rdW;
    logic [31:0] ALUresW;
    logic [31:0] data_readW;
    logic [31:0] pc4W;
    logic        misalignW;

    modport master (
        output regwriteM, memrwM, memreadM, funct3M, wbselM, rdM,
               data_writeM, ALUresM, pc4M, stallM, flushW,
        input  regwriteW, wbselW, rdW, ALUresW, data_readW, pc4W, misalignW
    );

    modport slave (
        input  regwriteM, memrwM, memreadM, funct3M, wbselM, rdM,
               data_writeM, ALUresM, pc4M, stallM, flushW,
        output regwriteW, wbselW, rdW, ALUresW, data_readW, pc4W, misalignW
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// RV32I MEM stage: byte-lane stores, synchronous-read data memory, load extension and the
// MEM/WB pipeline register with stall/flush hooks for the hazard unit.
module mem_stage_lsu #(
    parameter int ADDR_W    = 8,
    parameter     INIT_FILE = ""
) (
    input logic           clk,
    input logic           rst_n,
    mem_stage_lsu_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [31:0]       memArray [DEPTH];
    logic [ADDR_W-1:0] wordIdx;
    logic [1:0]        byteOff;
    logic              isHalf;
    logic              isWord;
    logic              isLoad;
    logic              misaligned;
    logic              wen;
    logic [3:0]        byteEn;
    logic [31:0]       laneData;

    logic [31:0]       rdWord;
    logic [2:0]        funct3W;
    logic [1:0]        offW;
    logic              loadW;
    logic [7:0]        selByte;
    logic [15:0]       selHalf;
    logic [31:0]       extData;

    assign wordIdx    = bus.ALUresM[ADDR_W+1:2];
    assign byteOff    = bus.ALUresM[1:0];
    assign isHalf     = (bus.funct3M[1:0] == 2'b01);
    assign isWord     = (bus.funct3M[1:0] == 2'b10);
    // A store with memreadM also set is still just a store.
    assign isLoad     = bus.memreadM & ~bus.memrwM;
    assign misaligned = (bus.memrwM | bus.memreadM) &
                        ((isHalf & byteOff[0]) | (isWord & (byteOff != 2'b00)));
    assign wen        = rst_n & bus.memrwM & ~misaligned & ~bus.stallM & ~bus.flushW;

    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        byteEn   = 4'b0000;
        laneData = bus.data_writeM;
        case (bus.funct3M[1:0])
            2'b00: begin
                byteEn[byteOff] = 1'b1;
                laneData        = {4{bus.data_writeM[7:0]}};
            end
            2'b01: begin
                byteEn   = byteOff[1] ? 4'b1100 : 4'b0011;
                laneData = {2{bus.data_writeM[15:0]}};
            end
            default: byteEn = 4'b1111;
        endcase
    end

    // NOTE: the data array has no reset; only the pipeline register below is cleared.
    always_ff @(posedge clk) begin
        if (wen) begin
            for (int lane = 0; lane < 4; lane++) begin
                if (byteEn[lane]) memArray[wordIdx][8*lane +: 8] <= laneData[8*lane +: 8];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all fields update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.regwriteW <= 1'b0;
            bus.wbselW    <= '0;
            bus.rdW       <= '0;
            bus.ALUresW   <= '0;
            bus.pc4W      <= '0;
            bus.misalignW <= 1'b0;
            rdWord        <= '0;
            funct3W       <= '0;
            offW          <= '0;
            loadW         <= 1'b0;
        end else if (bus.flushW) begin
            bus.regwriteW <= 1'b0;
            bus.wbselW    <= '0;
            bus.rdW       <= '0;
            bus.ALUresW   <= '0;
            bus.pc4W      <= '0;
            bus.misalignW <= 1'b0;
            rdWord        <= '0;
            funct3W       <= '0;
            offW          <= '0;
            loadW         <= 1'b0;
        end else if (!bus.stallM) begin
            bus.regwriteW <= bus.regwriteM & ~(isLoad & misaligned);
            bus.wbselW    <= bus.wbselM;
            bus.rdW       <= bus.rdM;
            bus.ALUresW   <= bus.ALUresM;
            bus.pc4W      <= bus.pc4M;
            bus.misalignW <= misaligned;
            rdWord        <= memArray[wordIdx];
            funct3W       <= bus.funct3M;
            offW          <= byteOff;
            loadW         <= isLoad;
        end
    end

    assign selByte = rdWord[{offW, 3'b000} +: 8];
    assign selHalf = offW[1] ? rdWord[31:16] : rdWord[15:0];

    always_comb begin
        extData = rdWord;
        if (loadW) begin
            case (funct3W)
                3'b000:  extData = {{24{selByte[7]}}, selByte};
                3'b100:  extData = {24'h0, selByte};
                3'b001:  extData = {{16{selHalf[15]}}, selHalf};
                3'b101:  extData = {16'h0, selHalf};
                default: extData = rdWord;
            endcase
        end
    end

    assign bus.data_readW = extData;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: a byte-addressed memory model predicts the MEM/WB outputs,
// checked every cycle, with hand-computed literals for the key load results.
module tb_mem_stage_lsu;
    logic clk;
    logic rst_n;

    mem_stage_lsu_if bus ();

    mem_stage_lsu #(.ADDR_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic        regwrite;
        logic [1:0]  wbsel;
        logic [4:0]  rd;
        logic [31:0] alures;
        logic [31:0] dataRead;
        logic [31:0] pc4;
        logic        misalign;
        logic        dataKnown;
    } wExp_t;

    wExp_t       expW;
    logic [7:0]  modelMem [1024];
    bit          memKnown [1024];
    int          nVec;
    int          nFail;
    logic [31:0] pcCnt;

    localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic wExp_t clearedW();
        wExp_t w;
        w = '0;
        w.dataKnown = 1'b1;
        return w;
    endfunction

    // Spec-level model: byte-addressed memory, access size from funct3, pre-edge read.
    task automatic modelStep(input logic rw, mr, input logic [2:0] f3, input logic [31:0] addr,
                             data, pc4, input logic [4:0] rd, input logic rwr, stall, flush);
        int base, off, size;
        bit mis, load, known;
        logic [31:0] val;
        base = int'(addr[9:0]) & ~3;
        off  = int'(addr[1:0]);
        size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        mis  = (rw || mr) && ((off % size) != 0);
        load = mr && !rw;
        if (flush) begin
            expW = clearedW();
        end else if (!stall) begin
            val   = '0;
            known = 1'b1;
            if (load && !mis) begin
                for (int i = 0; i < size; i++) begin
                    val[8*i +: 8] = modelMem[base + off + i];
                    known = known && memKnown[base + off + i];
                end
                if (!f3[2] && size < 4 && val[8*size-1]) val = val | (32'hFFFF_FFFF << (8*size));
            end else if (load) begin
                known = 1'b0;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    val[8*i +: 8] = modelMem[base + i];
                    known = known && memKnown[base + i];
                end
            end
            expW.regwrite  = rwr && !(load && mis);
            expW.wbsel     = rd[1:0];
            expW.rd        = rd;
            expW.alures    = addr;
            expW.dataRead  = val;
            expW.pc4       = pc4;
            expW.misalign  = mis;
            expW.dataKnown = known;
        end
        if (rw && !mis && !stall && !flush) begin
            for (int i = 0; i < size; i++) begin
                modelMem[base + off + i] = data[8*i +: 8];
                memKnown[base + off + i] = 1'b1;
            end
        end
    endtask

    // Drive one instruction at a falling edge, update the model at the rising edge, return at the next falling edge.
    task automatic op(input logic rw, mr, input logic [2:0] f3, input logic [31:0] addr, data,
                      input logic [4:0] rd, input logic rwr, input logic stall = 1'b0,
                      input logic flush = 1'b0);
        pcCnt           = pcCnt + 32'd4;
        bus.memrwM      = rw;
        bus.memreadM    = mr;
        bus.funct3M     = f3;
        bus.ALUresM     = addr;
        bus.data_writeM = data;
        bus.rdM         = rd;
        bus.wbselM      = rd[1:0];
        bus.regwriteM   = rwr;
        bus.pc4M        = pcCnt;
        bus.stallM      = stall;
        bus.flushW      = flush;
        @(posedge clk);
        modelStep(rw, mr, f3, addr, data, pcCnt, rd, rwr, stall, flush);
        @(negedge clk);
    endtask

    task automatic sw(input logic [31:0] addr, data, input logic stall = 1'b0, input logic flush = 1'b0);
        op(1'b1, 1'b0, F_W, addr, data, 5'd0, 1'b0, stall, flush);
    endtask

    task automatic ld(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd);
        op(1'b0, 1'b1, f3, addr, 32'h0, rd, 1'b1);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("regwriteW", 32'(bus.regwriteW), 32'(expW.regwrite));
            check("wbselW",    32'(bus.wbselW),    32'(expW.wbsel));
            check("rdW",       32'(bus.rdW),       32'(expW.rd));
            check("ALUresW",   bus.ALUresW,        expW.alures);
            check("pc4W",      bus.pc4W,           expW.pc4);
            check("misalignW", 32'(bus.misalignW), 32'(expW.misalign));
            if (expW.dataKnown) check("data_readW", bus.data_readW, expW.dataRead);
        end
    end

    initial begin
        nVec  = 0;
        nFail = 0;
        pcCnt = 32'h100;
        expW  = clearedW();
        for (int i = 0; i < 1024; i++) memKnown[i] = 1'b0;
        rst_n = 1'b0;
        bus.memrwM = 1'b0; bus.memreadM = 1'b0; bus.funct3M = '0; bus.ALUresM = '0;
        bus.data_writeM = '0; bus.rdM = '0; bus.wbselM = '0; bus.regwriteM = 1'b0;
        bus.pc4M = '0; bus.stallM = 1'b0; bus.flushW = 1'b0;
        repeat (2) @(negedge clk);
        check("reset regwriteW", 32'(bus.regwriteW), 32'h0);
        check("reset data_readW", bus.data_readW, 32'h0);
        check("reset pc4W", bus.pc4W, 32'h0);
        rst_n = 1'b1;

        // 1: word store then load
        sw(32'h4, 32'hA5A5_A5A5);
        ld(F_W, 32'h4, 5'd5);
        check("t1 LW data", bus.data_readW, 32'hA5A5_A5A5);
        check("t1 LW rdW", 32'(bus.rdW), 32'd5);
        check("t1 LW regwriteW", 32'(bus.regwriteW), 32'd1);

        // 2: byte store into a word, store followed directly by load
        sw(32'h8, 32'h1234_5678);
        op(1'b1, 1'b0, F_B, 32'hA, 32'h0000_00EE, 5'd0, 1'b0);
        ld(F_W, 32'h8, 5'd6);
        check("t2 LW", bus.data_readW, 32'h12EE_5678);
        ld(F_B, 32'hA, 5'd7);
        check("t2 LB", bus.data_readW, 32'hFFFF_FFEE);
        ld(F_BU, 32'hA, 5'd8);
        check("t2 LBU", bus.data_readW, 32'h0000_00EE);

        // 3: upper-half store
        op(1'b1, 1'b0, F_H, 32'h6, 32'h0000_8001, 5'd0, 1'b0);
        ld(F_H, 32'h6, 5'd9);
        check("t3 LH", bus.data_readW, 32'hFFFF_8001);
        ld(F_HU, 32'h6, 5'd10);
        check("t3 LHU", bus.data_readW, 32'h0000_8001);
        ld(F_W, 32'h4, 5'd11);
        check("t3 LW", bus.data_readW, 32'h8001_A5A5);

        // 4: misaligned accesses
        ld(F_W, 32'h5, 5'd12);
        check("t4 LW@5 misalignW", 32'(bus.misalignW), 32'd1);
        check("t4 LW@5 regwriteW", 32'(bus.regwriteW), 32'd0);
        sw(32'h0, 32'h0);
        op(1'b1, 1'b0, F_H, 32'h3, 32'h0000_FFFF, 5'd13, 1'b1);
        check("t4 SH@3 misalignW", 32'(bus.misalignW), 32'd1);
        check("t4 SH@3 regwriteW", 32'(bus.regwriteW), 32'd1);
        op(1'b1, 1'b0, F_H, 32'h5, 32'h0000_1234, 5'd0, 1'b0);
        sw(32'h6, 32'hDEAD_BEEF);
        ld(F_W, 32'h0, 5'd14);
        check("t4 word0 unchanged", bus.data_readW, 32'h0);
        ld(F_W, 32'h4, 5'd15);
        check("t4 word1 unchanged", bus.data_readW, 32'h8001_A5A5);
        op(1'b1, 1'b1, F_W, 32'h4, 32'h0BAD_F00D, 5'd16, 1'b1);
        check("t4 rw+rd regwriteW", 32'(bus.regwriteW), 32'd1);

        // 5: stall holds, flush bubbles and suppresses stores
        ld(F_W, 32'h4, 5'd7);
        sw(32'hC, 32'hCAFE_F00D, 1'b1);
        sw(32'hC, 32'hCAFE_F00D, 1'b1);
        check("t5 stall holds rdW", 32'(bus.rdW), 32'd7);
        check("t5 stall holds data", bus.data_readW, 32'h0BAD_F00D);
        sw(32'hC, 32'hCAFE_F00D);
        ld(F_W, 32'hC, 5'd9);
        check("t5 LW after stall", bus.data_readW, 32'hCAFE_F00D);
        sw(32'hC, 32'h0000_DEAD, 1'b0, 1'b1);
        check("t5 flush rdW", 32'(bus.rdW), 32'd0);
        op(1'b0, 1'b1, F_W, 32'hC, 32'h0, 5'd3, 1'b1, 1'b1, 1'b1);
        check("t5 flush+stall regwriteW", 32'(bus.regwriteW), 32'd0);
        check("t5 flush+stall pc4W", bus.pc4W, 32'd0);
        ld(F_W, 32'hC, 5'd9);
        check("t5 flushed store dropped", bus.data_readW, 32'hCAFE_F00D);

        // 6: address aliasing and asynchronous reset
        ld(F_W, 32'h404, 5'd17);
        check("t6 alias read", bus.data_readW, 32'h0BAD_F00D);
        sw(32'h404, 32'h1122_3344);
        ld(F_W, 32'h4, 5'd18);
        check("t6 alias write", bus.data_readW, 32'h1122_3344);
        #2;
        rst_n = 1'b0;
        expW  = clearedW();
        #1;
        check("t6 async rst regwriteW", 32'(bus.regwriteW), 32'h0);
        check("t6 async rst rdW", 32'(bus.rdW), 32'h0);
        check("t6 async rst ALUresW", bus.ALUresW, 32'h0);
        check("t6 async rst data_readW", bus.data_readW, 32'h0);
        check("t6 async rst pc4W", bus.pc4W, 32'h0);
        check("t6 async rst wbselW", 32'(bus.wbselW), 32'h0);
        check("t6 async rst misalignW", 32'(bus.misalignW), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        ld(F_HU, 32'h6, 5'd19);
        check("t6 memory survives reset", bus.data_readW, 32'h0000_1122);
        ld(F_B, 32'h7, 5'd20);
        check("t6 LB positive", bus.data_readW, 32'h0000_0011);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end
endmodule
